cpu_exec_controller: RTL
========================

Name: cpu_exec_controller

Overview:
Run/step/breakpoint sequencer for the four-bit CPU. It turns debounced front-panel presses into single-clock execute strobes, and the CPU retires exactly one instruction per strobe. Supports halt, single-step, free-run at a divided rate, and a PC-match breakpoint. It sits between the button press detectors and the CPU's instruction-execute enable, and replaces direct clocking of the CPU from the step button.

Parameters:
RATE_BITS, 10, run-mode strobe period is 2^RATE_BITS clocks; legal range 1..16.
PC_BITS, 3, width of the CPU program counter and breakpoint address.

Ports:
clock  input  1  system clock; everything is synchronous to its rising edge.
reset  input  1  synchronous, active-high reset.
stepPressed  input  1  one-clock pulse from the debounced step button.
runPressed  input  1  one-clock pulse from the debounced run/halt button; toggles between running and halted.
pressAck  output  1  one-clock pulse when a press is accepted.
breakEnable  input  1  enables the breakpoint comparator.
breakAddr  input  PC_BITS  breakpoint PC value.
pc  input  PC_BITS  current CPU program counter. It must be valid by the cycle after each execStrobe.
execStrobe  output  1  registered one-clock pulse; the CPU executes one instruction on the rising edge that ends this cycle.
state  output  3  current FSM state encoding.
running  output  1  high when state is RUN (drives an LED).
instrCount  output  8  number of strobes issued; wraps from 255 to 0.

Behaviour:
- Reset: synchronous. On the clock edge with reset=1, the block enters these values, overriding all other inputs including a strobe that would have issued:
  - state=HALT
  - execStrobe=0, pressAck=0, running=0
  - instrCount=0, rateCnt=0, skipBreak=0
- States and encodings:
  - HALT=0
  - STEP_EXEC=1
  - STEP_SETTLE=2
  - RUN=3
  - BREAK=4
  - Encodings 5..7 are illegal and return to HALT on the next clock.
- HALT:
  - runPressed goes to RUN.
  - Else stepPressed goes to STEP_EXEC.
  - If both arrive in the same cycle, runPressed wins and stepPressed is dropped without ack.
- BREAK: same transitions as HALT.
- Entering RUN (from HALT or BREAK): clears rateCnt and sets skipBreak=1.
- STEP_EXEC:
  - execStrobe=1 for exactly this cycle.
  - Always goes to STEP_SETTLE next.
- STEP_SETTLE:
  - execStrobe=0 and one cycle of dwell for the pc update.
  - Then goes to HALT.
  - Any press seen during STEP_EXEC or STEP_SETTLE is ignored and not acked.
- RUN:
  - rateCnt increments every clock.
  - At terminal count (2^RATE_BITS-1), the following priority applies:
    - a) runPressed goes to HALT and no strobe is issued.
    - b) If breakEnable=1, pc==breakAddr and skipBreak=0, go to BREAK and issue no strobe.
    - c) Otherwise execStrobe pulses in the next cycle, skipBreak clears, rateCnt wraps to 0, and the state stays RUN.
  - runPressed at a non-terminal count goes to HALT immediately and no strobe is issued.
  - stepPressed in RUN is ignored and not acked.
- Strobe timing: execStrobe is registered and asserted in the cycle after the decision edge.
  - First run strobe: in the (2^RATE_BITS+1)th cycle after entry into RUN.
  - Steady-state run period: 2^RATE_BITS clocks.
  - A strobe already registered still completes when the state changes to HALT.
- pressAck: high for one cycle after each accepted press, aligned with the state change.
- instrCount: +1 on every cycle where execStrobe=1; wraps modulo 256.
- skipBreak: lets run or step resume from a breakpoint without re-trapping on the same PC. Stepping from BREAK always executes and does not consult the breakpoint.
- breakEnable=0: breakpoint logic is inert; the comparator output is ignored.
- running = (state==RUN).
- Reset mid-run or mid-step: returns to HALT with no strobe.

Test Plan:
1. Step from HALT. Reset, then pulse stepPressed once -> state goes 1,2,0; execStrobe is high exactly one cycle; pressAck pulses once; instrCount=1.
2. Free run. RATE_BITS=2, runPressed for 20 clocks -> strobes every 4 clocks, first strobe 5 cycles after entry; running=1; instrCount=4; a second runPressed -> HALT and no further strobes.
3. Breakpoint.
   - Setup: breakEnable=1, breakAddr=3, pc model increments on each strobe from 0.
   - Run -> strobes at pc 0,1,2, then state=4 (BREAK) with pc=3 and no fourth strobe.
   - runPressed -> next strobe executes at pc=3, then the run continues.
4. Simultaneous presses in HALT. stepPressed and runPressed in the same cycle -> state=3, one pressAck, no STEP_EXEC entry.
5. Ignored presses. stepPressed during STEP_SETTLE and during RUN -> no pressAck, no extra strobe, instrCount unchanged.
6. Reset and wrap.
   - Assert reset in the same cycle as a RUN terminal count -> no strobe next cycle; state=0; instrCount=0.
   - Separately, after 256 strobes -> instrCount=0.

Source files
------------

// File: rtl/cpu_exec_controller.sv
// Run/step/breakpoint sequencer for the four-bit CPU.
// Converts front-panel presses into single-clock execute strobes.
module cpu_exec_controller #(
  parameter int RATE_BITS = 10,
  parameter int PC_BITS   = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stepPressed,
  input  logic               runPressed,
  output logic               pressAck,
  input  logic               breakEnable,
  input  logic [PC_BITS-1:0] breakAddr,
  input  logic [PC_BITS-1:0] pc,
  output logic               execStrobe,
  output logic [2:0]         state,
  output logic               running,
  output logic [7:0]         instrCount
);

  typedef enum logic [2:0] {
    HALT        = 3'd0,
    STEP_EXEC   = 3'd1,
    STEP_SETTLE = 3'd2,
    RUN         = 3'd3,
    BREAK       = 3'd4
  } state_t;

  localparam logic [RATE_BITS-1:0] RATE_ZERO = {RATE_BITS{1'b0}};
  localparam logic [RATE_BITS-1:0] RATE_ONE  = RATE_BITS'(32'd1);
  localparam logic [RATE_BITS-1:0] RATE_MAX  = {RATE_BITS{1'b1}};

  state_t               state_r;
  state_t               next_state_s;
  logic [RATE_BITS-1:0] rate_cnt_r;
  logic [RATE_BITS-1:0] rate_cnt_next_s;
  logic                 skip_break_r;
  logic                 skip_break_next_s;
  logic                 exec_strobe_r;
  logic                 exec_strobe_next_s;
  logic                 press_ack_r;
  logic                 press_ack_next_s;
  logic                 running_r;
  logic [7:0]           instr_count_r;
  logic                 terminal_s;
  logic                 break_hit_s;

  assign terminal_s  = (rate_cnt_r == RATE_MAX);
  // skipBreak lets a resumed run execute the instruction it trapped on.
  assign break_hit_s = breakEnable & (pc == breakAddr) & ~skip_break_r;

  // Next-state, strobe and acknowledge decisions.
  always_comb begin
    next_state_s       = state_r;
    rate_cnt_next_s    = rate_cnt_r;
    skip_break_next_s  = skip_break_r;
    exec_strobe_next_s = 1'b0;
    press_ack_next_s   = 1'b0;
    case (state_r)
      HALT, BREAK: begin
        if (runPressed) begin
          next_state_s      = RUN;
          rate_cnt_next_s   = RATE_ZERO;
          skip_break_next_s = 1'b1;
          press_ack_next_s  = 1'b1;
        end else if (stepPressed) begin
          next_state_s       = STEP_EXEC;
          exec_strobe_next_s = 1'b1;
          press_ack_next_s   = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      STEP_EXEC: begin
        next_state_s = STEP_SETTLE;
      end
      STEP_SETTLE: begin
        next_state_s = HALT;
      end
      RUN: begin
        rate_cnt_next_s = rate_cnt_r + RATE_ONE;
        if (runPressed) begin
          next_state_s     = HALT;
          press_ack_next_s = 1'b1;
        end else if (terminal_s) begin
          if (break_hit_s) begin
            next_state_s = BREAK;
          end else begin
            exec_strobe_next_s = 1'b1;
            skip_break_next_s  = 1'b0;
          end
        end else begin
          next_state_s = RUN;
        end
      end
      default: begin
        next_state_s = HALT;
      end
    endcase
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= HALT;
      rate_cnt_r    <= RATE_ZERO;
      skip_break_r  <= 1'b0;
      exec_strobe_r <= 1'b0;
      press_ack_r   <= 1'b0;
      running_r     <= 1'b0;
      instr_count_r <= 8'd0;
    end else begin
      state_r       <= next_state_s;
      rate_cnt_r    <= rate_cnt_next_s;
      skip_break_r  <= skip_break_next_s;
      exec_strobe_r <= exec_strobe_next_s;
      press_ack_r   <= press_ack_next_s;
      running_r     <= (next_state_s == RUN);
      instr_count_r <= instr_count_r + {7'd0, exec_strobe_r};
    end
  end

  assign state      = state_r;
  assign execStrobe = exec_strobe_r;
  assign pressAck   = press_ack_r;
  assign running    = running_r;
  assign instrCount = instr_count_r;

endmodule
